// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master requests an addition and the slave returns the result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop, LSB first,
// producing {Cout,Sum} = A + B + Cin after WIDTH busy cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sh_a_reg, sh_b_reg, acc_reg, sum_reg;
  logic             carry_reg, cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic             accept;
  logic             last_bit;
  logic             bit_sum;
  logic             carry_next;
  logic [WIDTH-1:0] acc_next;

  // A new request is taken whenever the datapath is not mid-addition.
  assign accept   = bus.start && (state_reg != RUN);
  assign last_bit = (state_reg == RUN) && (cnt_reg == LAST);

  always_comb begin
    bit_sum    = sh_a_reg[0] ^ sh_b_reg[0] ^ carry_reg;
    carry_next = (sh_a_reg[0] & sh_b_reg[0]) | (sh_a_reg[0] & carry_reg) |
                 (sh_b_reg[0] & carry_reg);
    acc_next   = {bit_sum, acc_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_reg)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Sum/Cout are only written on the final bit so they never show a partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a_reg  <= '0;
      sh_b_reg  <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      sh_a_reg  <= bus.A;
      sh_b_reg  <= bus.B;
      acc_reg   <= '0;
      carry_reg <= bus.Cin;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      sh_a_reg  <= sh_a_reg >> 1;
      sh_b_reg  <= sh_b_reg >> 1;
      acc_reg   <= acc_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_reg + CW'(1);
      if (last_bit) begin
        sum_reg  <= acc_next;
        cout_reg <= carry_next;
      end
    end
  end

  assign bus.Sum  = sum_reg;
  assign bus.Cout = cout_reg;
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder. Adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop.
- It is the addition-side companion to the combinational half/full subtractor blocks in the arithmetic library.
- Used where area matters more than latency. Its start/busy/done handshake lets a controller sequence operations.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- A  input  WIDTH  operand A; captured on an accepted start
- B  input  WIDTH  operand B; captured on an accepted start
- Cin  input  1  carry-in; captured on an accepted start
- busy  output  1  high while a bit-serial addition is in progress
- done  output  1  one-cycle pulse when Sum/Cout become valid
- Sum  output  WIDTH  result, A+B+Cin modulo 2^WIDTH
- Cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, Sum=0, Cout=0.
  - Internal shift registers, carry FF and bit counter are cleared.
  - Reset asserted mid-operation aborts the addition. No done pulse is produced.
- FSM states:
  - IDLE: busy=0, done=0. If start=1 at a rising edge: load shA<=A, shB<=B, carry<=Cin, cnt<=0, go to RUN.
  - RUN: busy=1. On each edge:
    - s = shA[0]^shB[0]^carry.
    - carry <= majority(shA[0], shB[0], carry).
    - shA and shB shift right by 1.
    - s shifts into the accumulator MSB (accumulator shifts right).
    - cnt <= cnt+1.
    - On the edge where cnt==WIDTH-1: go to DONE. Sum <= final accumulator (including this bit), Cout <= final carry.
  - DONE: busy=0, done=1 for exactly this cycle. If start=1: accept a new operation exactly as from IDLE (back-to-back) and go to RUN. Otherwise go to IDLE.
- Handshake:
  - start is ignored while busy=1. No queuing; operands are not re-sampled.
  - Operand inputs are don't-care except on the accepting edge.
- Latency:
  - Start accepted at edge k.
  - busy=1 for cycles k+1 .. k+WIDTH (exactly WIDTH cycles).
  - done=1 in cycle k+WIDTH+1.
  - Accepted-start to done = WIDTH+1 edges.
- Output hold:
  - Sum/Cout update only on the RUN->DONE transition.
  - They hold their value through IDLE and through the next operation until its completion. They are never partially updated.
- Arithmetic: {Cout,Sum} = A + B + Cin, treated as unsigned. Overflow is reported only via Cout; there is no signed-overflow flag.
- Counter: width is clog2(WIDTH). It does not wrap during normal use and is cleared on every accepted start.
- Simultaneous events:
  - start during the done cycle is accepted; done still pulses for the finishing operation.
  - Reset has priority over everything.

Test Plan:
- WIDTH=8, A=8'h3C, B=8'h05, Cin=0, start pulse -> busy high 8 cycles; done pulses on 9th cycle after the accepting edge; Sum=8'h41, Cout=0.
- A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1. A=8'h00, B=8'h00, Cin=1 -> Sum=8'h01, Cout=0.
- Start op A=8'h10, B=8'h20; assert start with A=8'hAA, B=8'h55 on cycle 3 of busy -> ignored. Result Sum=8'h30, Cout=0, exactly one done pulse.
- Back-to-back: A=8'h7F+B=8'h01, then start=1 during its done cycle with A=8'h80, B=8'h80, Cin=1:
  - First result is Sum=8'h80, Cout=0.
  - Busy re-asserts the next cycle.
  - Second result is Sum=8'h01, Cout=1.
- Reset mid-operation: deassert rst_n during cycle 4 of busy -> busy, done, Sum, Cout go to 0 immediately (asynchronously). No done pulse follows. A subsequent start with A=8'h01, B=8'h02 gives Sum=8'h03.
- Random/exhaustive check (WIDTH=4, all 512 A/B/Cin combinations) against a behavioural A+B+Cin model -> zero mismatches; done count equals start-accept count.
